viterbi_decoder_p: RTL

VITERBI_DECODER_P -- requirements
Module: viterbi_decoder_p

---
 rtl/viterbi_decoder_p.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/viterbi_decoder_p.sv
// Hard-decision rate-1/2 Viterbi decoder: one ACS step per cycle over a latched frame,
// then a one-step-per-cycle traceback, with saturating path metrics.

module viterbi_acs_unit #(
  parameter int           K        = 3,
  parameter logic [K-1:0] G0       = 3'b111,
  parameter logic [K-1:0] G1       = 3'b101,
  parameter int           METRIC_W = 8,
  parameter int           STATE    = 0
) (
  input  logic [1:0]          sym_i,
  input  logic [METRIC_W-1:0] pm0_i,
  input  logic [METRIC_W-1:0] pm1_i,
  output logic [METRIC_W-1:0] pm_o,
  output logic                dec_o
);
  // Encoder register for the branch into STATE: {new state, oldest bit of predecessor}.
  localparam logic [K-1:0] R0 = K'(STATE << 1);
  localparam logic [K-1:0] R1 = K'((STATE << 1) | 1);
  localparam logic [1:0]   E0 = {^(R0 & G0), ^(R0 & G1)};
  localparam logic [1:0]   E1 = {^(R1 & G0), ^(R1 & G1)};

  logic [METRIC_W-1:0] c0, c1;

  function automatic logic [METRIC_W-1:0] sat_add(input logic [METRIC_W-1:0] a,
                                                  input logic [1:0] e, input logic [1:0] r);
    logic [METRIC_W:0] s;
    s = {1'b0, a} + (METRIC_W+1)'(e[1] ^ r[1]) + (METRIC_W+1)'(e[0] ^ r[0]);
    return s[METRIC_W] ? '1 : s[METRIC_W-1:0];
  endfunction

  always_comb begin
    c0    = sat_add(pm0_i, E0, sym_i);
    c1    = sat_add(pm1_i, E1, sym_i);
    // Ties go to the predecessor whose discarded bit is 0.
    dec_o = (c1 < c0);
    pm_o  = dec_o ? c1 : c0;
  end
endmodule

module viterbi_decoder_p #(
  parameter int           N_BITS    = 7,
  parameter int           K         = 3,
  parameter logic [K-1:0] G0        = 3'b111,
  parameter logic [K-1:0] G1        = 3'b101,
  parameter int           METRIC_W  = 8,
  parameter bit           TAIL_ZERO = 1'b0
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic [2*N_BITS-1:0] dat_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [N_BITS-1:0]   out_o,
  output logic [METRIC_W-1:0] metric_o
);
  localparam int SW = K - 1;
  localparam int NS = 1 << SW;
  localparam int CW = $clog2(N_BITS);

  typedef enum logic [1:0] {IDLE, ACS, TRACE, DONE} state_e;

  state_e                      state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [2*N_BITS-1:0]         dat_q, dat_d;
  logic [NS-1:0][METRIC_W-1:0] pm_q, pm_d, pm_acs;
  logic [NS-1:0]               dec_acs;
  logic [N_BITS-1:0][NS-1:0]   surv_q, surv_d;
  logic [SW-1:0]               tb_q, tb_d, best;
  logic [METRIC_W-1:0]         smet_q, smet_d;
  logic [N_BITS-1:0]           bits_q, bits_d;
  logic [N_BITS-1:0]           out_q, out_d;
  logic [METRIC_W-1:0]         metric_q, metric_d;

  // Predecessors of state s are (2s mod NS) and that plus one.
  for (genvar s = 0; s < NS; s++) begin : g_acs
    viterbi_acs_unit #(
      .K(K), .G0(G0), .G1(G1), .METRIC_W(METRIC_W), .STATE(s)
    ) u_acs (
      .sym_i (dat_q[2*N_BITS-1 -: 2]),
      .pm0_i (pm_q[(2*s) % NS]),
      .pm1_i (pm_q[(2*s) % NS + 1]),
      .pm_o  (pm_acs[s]),
      .dec_o (dec_acs[s])
    );
  end

  always_comb begin
    int bi;
    bi = 0;
    for (int s = 1; s < NS; s++)
      if (pm_acs[s] < pm_acs[bi]) bi = s;
    best = SW'(bi);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dat_d    = dat_q;
    pm_d     = pm_q;
    surv_d   = surv_q;
    tb_d     = tb_q;
    smet_d   = smet_q;
    bits_d   = bits_q;
    out_d    = out_q;
    metric_d = metric_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = ACS;
        dat_d   = dat_i;
        cnt_d   = '0;
        for (int s = 0; s < NS; s++) pm_d[s] = (s == 0) ? '0 : '1;
      end
      ACS: begin
        pm_d          = pm_acs;
        surv_d[cnt_q] = dec_acs;
        dat_d         = dat_q << 2;
        if (cnt_q == CW'(N_BITS-1)) begin
          // Counter stays at the last step, which is where traceback begins.
          state_d = TRACE;
          tb_d    = TAIL_ZERO ? '0 : best;
          smet_d  = TAIL_ZERO ? pm_acs[0] : pm_acs[best];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TRACE: begin
        bits_d[CW'(N_BITS-1) - cnt_q] = tb_q[SW-1];
        tb_d = {tb_q[SW-2:0], surv_q[cnt_q][tb_q]};
        if (cnt_q == '0) begin
          state_d  = DONE;
          out_d    = bits_d;
          metric_d = smet_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      out_q    <= '0;
      metric_q <= '0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      metric_q <= metric_d;
    end
  end

  // Datapath is fully reloaded on acceptance, so it carries no reset.
  always_ff @(posedge clk_i) begin
    cnt_q  <= cnt_d;
    dat_q  <= dat_d;
    pm_q   <= pm_d;
    surv_q <= surv_d;
    tb_q   <= tb_d;
    smet_q <= smet_d;
    bits_q <= bits_d;
  end

  assign busy_o   = (state_q != IDLE);
  assign done_o   = (state_q == DONE);
  assign out_o    = out_q;
  assign metric_o = metric_q;
endmodule
